// File: rtl/ir_tx_pkg.sv
// Shared types, FSM states and per-colour burst defaults for the IR packet transmitter.
package ir_tx_pkg;

    typedef logic [16:0] carrier_cnt_t;
    typedef logic [7:0]  len_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_GAP0   = 4'd2,
        ST_SELECT = 4'd3,
        ST_GAP1   = 4'd4,
        ST_RIGHT  = 4'd5,
        ST_GAP2   = 4'd6,
        ST_LEFT   = 4'd7,
        ST_GAP3   = 4'd8,
        ST_BACK   = 4'd9,
        ST_GAP4   = 4'd10,
        ST_FWD    = 4'd11,
        ST_GAP5   = 4'd12
    } tx_state_e;

    typedef struct packed {
        len_t start_len;
        len_t select_len;
        len_t gap_len;
        len_t assert_len;
        len_t deassert_len;
    } burst_cfg_t;

    // Cars differ only in the select burst; everything else is shared.
    localparam burst_cfg_t CFG_BLUE   = '{8'd191, 8'd47,  8'd25, 8'd47, 8'd22};
    localparam burst_cfg_t CFG_YELLOW = '{8'd191, 8'd84,  8'd25, 8'd47, 8'd22};
    localparam burst_cfg_t CFG_GREEN  = '{8'd191, 8'd122, 8'd25, 8'd47, 8'd22};
    localparam burst_cfg_t CFG_RED    = '{8'd191, 8'd159, 8'd25, 8'd47, 8'd22};

    function automatic logic is_burst(input tx_state_e st);
        logic b;
        case (st)
            ST_START, ST_SELECT, ST_RIGHT, ST_LEFT, ST_BACK, ST_FWD: b = 1'b1;
            default:                                                 b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic tx_state_e next_state(input tx_state_e st);
        tx_state_e n;
        case (st)
            ST_START:  n = ST_GAP0;
            ST_GAP0:   n = ST_SELECT;
            ST_SELECT: n = ST_GAP1;
            ST_GAP1:   n = ST_RIGHT;
            ST_RIGHT:  n = ST_GAP2;
            ST_GAP2:   n = ST_LEFT;
            ST_LEFT:   n = ST_GAP3;
            ST_GAP3:   n = ST_BACK;
            ST_BACK:   n = ST_GAP4;
            ST_GAP4:   n = ST_FWD;
            ST_FWD:    n = ST_GAP5;
            default:   n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier counter: wraps over one carrier period, flags the last count of each period.
// IR_TX_CARRIER_EN selects a modulated carrier; otherwise carrier_o is held high.
module ir_carrier_gen
    import ir_tx_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1389
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic carrier_o,
    output logic period_end_o
);

    localparam carrier_cnt_t LAST_CNT = carrier_cnt_t'(2 * HALF_PERIOD - 1);

    carrier_cnt_t cnt_q;
    carrier_cnt_t cnt_d;

    // Next count: clear wins, otherwise wrap at the end of a period while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 17'd0;
        end else if (en_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = 17'd0;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 17'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign period_end_o = (cnt_q == LAST_CNT);

`ifdef IR_TX_CARRIER_EN
    localparam carrier_cnt_t HIGH_CNT = carrier_cnt_t'(HALF_PERIOD);
    assign carrier_o = (cnt_q < HIGH_CNT);
`else
    assign carrier_o = 1'b1;
`endif

endmodule

// File: rtl/ir_packet_tx.sv
// Sends one remote-car IR packet per rising edge of SEND_IN; IDLE ignores nothing, busy states ignore triggers.
// Carrier modulation of IR_LED is controlled by IR_TX_CARRIER_EN (see ir_carrier_gen).
module ir_packet_tx
    import ir_tx_pkg::*;
#(
    parameter int unsigned HALF_PERIOD  = 1389,
    parameter int unsigned START_LEN    = 191,
    parameter int unsigned SELECT_LEN   = 47,
    parameter int unsigned GAP_LEN      = 25,
    parameter int unsigned ASSERT_LEN   = 47,
    parameter int unsigned DEASSERT_LEN = 22
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SEND_IN,
    input  logic [3:0] COMMAND,
    output logic       IR_LED,
    output logic       BUSY
);

    localparam len_t START_L    = len_t'(START_LEN);
    localparam len_t SELECT_L   = len_t'(SELECT_LEN);
    localparam len_t GAP_L      = len_t'(GAP_LEN);
    localparam len_t ASSERT_L   = len_t'(ASSERT_LEN);
    localparam len_t DEASSERT_L = len_t'(DEASSERT_LEN);

    tx_state_e  state_q, state_d;
    logic [3:0] cmd_q, cmd_d;
    len_t       period_q, period_d;
    logic       send_q;
    logic       armed_q;
    len_t       len_s;
    logic       trigger_s;
    logic       carrier_s;
    logic       period_end_s;

    // The first clock after reset only loads the edge register, so a level already high is not an edge.
    assign trigger_s = SEND_IN & ~send_q & armed_q;

    ir_carrier_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_carrier (
        .clk_i        (CLK),
        .rst_n_i      (RESET_N),
        .en_i         (state_q != ST_IDLE),
        .clr_i        ((state_q == ST_IDLE) & trigger_s),
        .carrier_o    (carrier_s),
        .period_end_o (period_end_s)
    );

    // Length of the current state in carrier periods.
    always_comb begin
        len_s = GAP_L;
        case (state_q)
            ST_START:  len_s = START_L;
            ST_SELECT: len_s = SELECT_L;
            ST_RIGHT:  len_s = cmd_q[3] ? ASSERT_L : DEASSERT_L;
            ST_LEFT:   len_s = cmd_q[2] ? ASSERT_L : DEASSERT_L;
            ST_BACK:   len_s = cmd_q[1] ? ASSERT_L : DEASSERT_L;
            ST_FWD:    len_s = cmd_q[0] ? ASSERT_L : DEASSERT_L;
            default:   len_s = GAP_L;
        endcase
    end

    // Next-state, command latch and period counter.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        period_d = period_q;
        if (state_q == ST_IDLE) begin
            if (trigger_s) begin
                cmd_d    = COMMAND;
                period_d = 8'd0;
                state_d  = ST_START;
            end else begin
                state_d  = ST_IDLE;
            end
        end else if (period_end_s) begin
            if (period_q == (len_s - 8'd1)) begin
                period_d = 8'd0;
                state_d  = next_state(state_q);
            end else begin
                period_d = period_q + 8'd1;
            end
        end else begin
            period_d = period_q;
        end
    end

    // State, command and edge-detect registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 4'd0;
            period_q <= 8'd0;
            send_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            period_q <= period_d;
            send_q   <= SEND_IN;
            armed_q  <= 1'b1;
        end
    end

    assign IR_LED = carrier_s & is_burst(state_q);
    assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_packet_tx.sv
// Randomised self-checking bench for ir_packet_tx against a per-cycle waveform model.
module tb_ir_packet_tx;

    localparam int HP   = 2;
    localparam int ST_L = 4;
    localparam int SE_L = 2;
    localparam int GP_L = 1;
    localparam int AS_L = 3;
    localparam int DE_L = 1;
`ifdef IR_TX_CARRIER_EN
    localparam int LED_PER_PERIOD = HP;
    localparam int MAX_RUN_0000   = HP;
`else
    localparam int LED_PER_PERIOD = 2 * HP;
    localparam int MAX_RUN_0000   = ST_L * 2 * HP;
`endif

    logic       CLK;
    logic       RESET_N;
    logic       SEND_IN;
    logic [3:0] COMMAND;
    logic       IR_LED;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];
    logic       m_busy, m_led, m_prev, m_armed;
    int         cnt_busy, cnt_led, run, max_run;

    ir_packet_tx #(
        .HALF_PERIOD  (HP),
        .START_LEN    (ST_L),
        .SELECT_LEN   (SE_L),
        .GAP_LEN      (GP_L),
        .ASSERT_LEN   (AS_L),
        .DEASSERT_LEN (DE_L)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .SEND_IN (SEND_IN),
        .COMMAND (COMMAND),
        .IR_LED  (IR_LED),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int burst_len(input logic b);
        return b ? AS_L : DE_L;
    endfunction

    // Expand a command into the whole expected packet, one entry {busy, led} per clock.
    task automatic build(input logic [3:0] cmd);
        int   seg_len[12];
        logic seg_on[12];
        logic led;
        seg_len = '{ST_L, GP_L, SE_L, GP_L, burst_len(cmd[3]), GP_L,
                    burst_len(cmd[2]), GP_L, burst_len(cmd[1]), GP_L, burst_len(cmd[0]), GP_L};
        for (int s = 0; s < 12; s++) seg_on[s] = (s % 2 == 0);
        seg_on[1] = 1'b0;
        seg_on[2] = 1'b1;
        for (int s = 0; s < 12; s++) begin
            for (int p = 0; p < seg_len[s]; p++) begin
                for (int c = 0; c < 2 * HP; c++) begin
                    led = seg_on[s];
`ifdef IR_TX_CARRIER_EN
                    led = led && (c < HP);
`endif
                    exp_q.push_back({1'b1, led});
                end
            end
        end
    endtask

    task automatic clr_stats();
        cnt_busy = 0;
        cnt_led  = 0;
        run      = 0;
        max_run  = 0;
    endtask

    // Advance the model by the coming clock edge, then compare at the following falling edge.
    task automatic tick();
        logic [1:0] e;
        if (!RESET_N) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_led   = 1'b0;
            m_prev  = 1'b0;
            m_armed = 1'b0;
        end else begin
            if (!m_busy && m_armed && SEND_IN && !m_prev) build(COMMAND);
            if (m_busy || exp_q.size() > 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    m_busy = e[1];
                    m_led  = e[0];
                end else begin
                    m_busy = 1'b0;
                    m_led  = 1'b0;
                end
            end
            m_prev  = SEND_IN;
            m_armed = 1'b1;
        end
        @(negedge CLK);
        chk("busy", BUSY, m_busy);
        chk("ir_led", IR_LED, m_led);
        cnt_busy += int'(BUSY);
        cnt_led  += int'(IR_LED);
        run = IR_LED ? run + 1 : 0;
        if (run > max_run) max_run = run;
    endtask

    task automatic reset_mid(input int n);
        COMMAND = 4'b1111;
        SEND_IN = 1'b1;
        clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (n - 1) tick();
        chk("busy_before_reset", cnt_busy, n);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_busy", BUSY, 1'b0);
        chk("async_led", IR_LED, 1'b0);
        tick();
        RESET_N = 1'b1;
        clr_stats();
        repeat (100) tick();
        chk("after_reset_busy", cnt_busy, 0);
    endtask

    initial begin
        int hi, lo;
        RESET_N = 1'b0;
        SEND_IN = 1'b0;
        COMMAND = 4'd0;
        m_busy = 1'b0; m_led = 1'b0; m_prev = 1'b0; m_armed = 1'b0;
        clr_stats();
        repeat (2) @(negedge CLK);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_led", IR_LED, 1'b0);
        RESET_N = 1'b1;
        repeat (5) tick();

        // Single packet, all command bits clear.
        COMMAND = 4'b0000; SEND_IN = 1'b1; clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (79) tick();
        chk("busy_0000", cnt_busy, 64);
        chk("led_0000", cnt_led, 10 * LED_PER_PERIOD);
        chk("run_0000", max_run, MAX_RUN_0000);

        // All command bits set.
        COMMAND = 4'b1111; SEND_IN = 1'b1; clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (99) tick();
        chk("busy_1111", cnt_busy, 96);
        chk("led_1111", cnt_led, 18 * LED_PER_PERIOD);

        // Command changed during START must not matter.
        COMMAND = 4'b1010; SEND_IN = 1'b1; clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (4) tick();
        COMMAND = 4'b0101;
        repeat (90) tick();
        chk("busy_1010", cnt_busy, 80);
        chk("led_1010", cnt_led, 14 * LED_PER_PERIOD);

        // Second edge ten clocks in is ignored.
        COMMAND = 4'b0000; SEND_IN = 1'b1; clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (9) tick();
        SEND_IN = 1'b1;
        tick();
        SEND_IN = 1'b0;
        repeat (80) tick();
        chk("busy_retrigger", cnt_busy, 64);

        // Level held high sends exactly one packet.
        SEND_IN = 1'b1; clr_stats();
        repeat (200) tick();
        SEND_IN = 1'b0;
        repeat (5) tick();
        chk("busy_held", cnt_busy, 64);

        // Back-to-back packets with a new edge right after the previous one ends.
        SEND_IN = 1'b1; clr_stats();
        tick();
        SEND_IN = 1'b0;
        repeat (64) tick();
        SEND_IN = 1'b1;
        tick();
        SEND_IN = 1'b0;
        repeat (73) tick();
        chk("busy_b2b", cnt_busy, 128);

        // Reset mid-packet, at clock 30 and inside the first burst.
        reset_mid(30);
        reset_mid(1);

        // SEND_IN already high when reset releases: no packet.
        COMMAND = 4'b0000; SEND_IN = 1'b1;
        tick(); tick();
        #2 RESET_N = 1'b0;
        #1;
        chk("async_busy_held", BUSY, 1'b0);
        tick();
        RESET_N = 1'b1; clr_stats();
        repeat (100) tick();
        chk("no_packet_high_release", cnt_busy, 0);
        SEND_IN = 1'b0;
        repeat (3) tick();

        // Random commands, pulse widths and mid-packet command changes.
        for (int i = 0; i < 15; i++) begin
            COMMAND = 4'($urandom);
            SEND_IN = 1'b1;
            hi = $urandom_range(1, 90);
            lo = $urandom_range(1, 30);
            repeat (hi) begin
                if ($urandom_range(0, 3) == 0) COMMAND = 4'($urandom);
                tick();
            end
            SEND_IN = 1'b0;
            repeat (lo) tick();
        end
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
